// File: rtl/cpu15_pkg.sv
// rtl/cpu15_pkg.sv - shared opcode constants and sequencer state encoding
package cpu15_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } state_t;

    localparam logic [3:0] OP_LD  = 4'hd;
    localparam logic [3:0] OP_ST  = 4'he;
    localparam logic [3:0] OP_HLT = 4'hf;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction

endpackage

// File: rtl/cpu_seq_if.sv
// rtl/cpu_seq_if.sv - sequencer control/handshake bundle
interface cpu_seq_if #(
    parameter int CNT_W = 16
);
    logic             RUN;
    logic             STEP;
    logic [3:0]       OP_CODE;
    logic             ROM_REQ;
    logic             ROM_ACK;
    logic             RAM_REQ;
    logic             RAM_ACK;
    logic             EN_FT;
    logic             EN_DC;
    logic             EN_EX;
    logic             EN_WB;
    logic             BUSY;
    logic             HALTED;
    logic             FAULT;
    logic [CNT_W-1:0] INSN_CNT;

    // master is the sequencer, which issues ROM/RAM requests
    modport master (
        input  RUN, STEP, OP_CODE, ROM_ACK, RAM_ACK,
        output ROM_REQ, RAM_REQ, EN_FT, EN_DC, EN_EX, EN_WB,
        output BUSY, HALTED, FAULT, INSN_CNT
    );

    modport slave (
        output RUN, STEP, OP_CODE, ROM_ACK, RAM_ACK,
        input  ROM_REQ, RAM_REQ, EN_FT, EN_DC, EN_EX, EN_WB,
        input  BUSY, HALTED, FAULT, INSN_CNT
    );
endinterface

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - counts un-acknowledged request cycles, flags timeout
module wait_timer #(
    parameter int ACK_TO = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    // expired fires in the ACK_TO-th consecutive waiting cycle
    localparam logic [7:0] LIMIT = 8'(ACK_TO - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= 8'd0;
        end else if (count_en && (cnt != 8'hff)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expired = count_en && (cnt == LIMIT);

endmodule

// File: rtl/cpu_seq.sv
// rtl/cpu_seq.sv - fetch/decode/mem/exec/write-back instruction sequencer
module cpu_seq
    import cpu15_pkg::*;
#(
    parameter int ACK_TO = 15,
    parameter int CNT_W  = 16
) (
    input  logic      CLK,
    input  logic      RESET,
    cpu_seq_if.master bus
);
    state_t           state;
    state_t           state_nx;
    logic             rom_req;
    logic             ram_req;
    logic             en_ft;
    logic             en_dc;
    logic             en_ex;
    logic             en_wb;
    logic             halted;
    logic             fault;
    logic             busy;
    logic             expired;
    logic             waiting;
    logic [CNT_W-1:0] insn_cnt;

    // the timer sits at zero outside FETCH/MEM, so each entry starts a fresh wait
    assign waiting = (state == ST_FETCH) || (state == ST_MEM);

    wait_timer #(.ACK_TO(ACK_TO)) u_wait_timer (
        .clk      (CLK),
        .rst      (RESET),
        .clear    (!waiting),
        .count_en ((state == ST_FETCH && !bus.ROM_ACK) || (state == ST_MEM && !bus.RAM_ACK)),
        .expired  (expired)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rom_req  = 1'b0;
        ram_req  = 1'b0;
        en_ft    = 1'b0;
        en_dc    = 1'b0;
        en_ex    = 1'b0;
        en_wb    = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.RUN || bus.STEP) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                rom_req = 1'b1;
                // ACK beats a coincident timeout
                if (bus.ROM_ACK) begin
                    en_ft    = 1'b1;
                    state_nx = ST_DECODE;
                end else if (expired) begin
                    state_nx = ST_FAULT;
                end
            end
            ST_DECODE: begin
                en_dc    = 1'b1;
                state_nx = is_mem_op(bus.OP_CODE) ? ST_MEM : ST_EXEC;
            end
            ST_MEM: begin
                ram_req = 1'b1;
                if (bus.RAM_ACK) begin
                    state_nx = ST_EXEC;
                end else if (expired) begin
                    state_nx = ST_FAULT;
                end
            end
            ST_EXEC: begin
                en_ex    = 1'b1;
                state_nx = (bus.OP_CODE == OP_HLT) ? ST_HALT : ST_WB;
            end
            ST_WB: begin
                en_wb    = 1'b1;
                state_nx = bus.RUN ? ST_FETCH : ST_IDLE;
            end
            ST_HALT:  halted = 1'b1;
            ST_FAULT: fault  = 1'b1;
            default:  state_nx = ST_IDLE;
        endcase
    end

    assign busy = !((state == ST_IDLE) || (state == ST_HALT) || (state == ST_FAULT));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            insn_cnt <= '0;
        end else if (state == ST_WB) begin
            insn_cnt <= insn_cnt + 1'b1;
        end
    end

    assign bus.ROM_REQ  = rom_req;
    assign bus.RAM_REQ  = ram_req;
    assign bus.EN_FT    = en_ft;
    assign bus.EN_DC    = en_dc;
    assign bus.EN_EX    = en_ex;
    assign bus.EN_WB    = en_wb;
    assign bus.BUSY     = busy;
    assign bus.HALTED   = halted;
    assign bus.FAULT    = fault;
    assign bus.INSN_CNT = insn_cnt;

endmodule

// File: doc/cpu_seq.md
CPU_SEQ -- requirements
Module: cpu_seq

Interface
REQ-001 SHALL have parameter: ACK_TO, 15, max wait cycles for ROM_ACK/RAM_ACK before fault (1..255).
REQ-002 SHALL have parameter: CNT_W, 16, width of retired-instruction counter.
REQ-003 SHALL have ports (clock and reset first):
  CLK  in  1  single clock; all state changes on rising edge.
  RESET  in  1  synchronous, active-high reset.
  RUN  in  1  level; free-run instruction sequencing.
  STEP  in  1  single-cycle pulse; execute one instruction while RUN=0.
  OP_CODE  in  4  opcode of the currently latched instruction.
  ROM_REQ  out  1  instruction fetch request.
  ROM_ACK  in  1  instruction word valid this cycle.
  RAM_REQ  out  1  data memory access request (LD/ST).
  RAM_ACK  in  1  data memory access complete this cycle.
  EN_FT  out  1  one-cycle strobe: latch instruction register.
  EN_DC  out  1  one-cycle strobe: decode/register-file read.
  EN_EX  out  1  one-cycle strobe: execute (exec-stage clock enable).
  EN_WB  out  1  one-cycle strobe: register/RAM write-back.
  BUSY  out  1  high in every state except IDLE, HALT, FAULT.
  HALTED  out  1  high while in HALT.
  FAULT  out  1  high while in FAULT.
  INSN_CNT  out  CNT_W  retired-instruction count.
REQ-004 SHALL use one clock, CLK; reset RESET is synchronous and active-high.

Function
REQ-005 SHALL implement states IDLE, FETCH, DECODE, MEM, EXEC, WB, HALT, FAULT; all outputs Moore-decoded from state, except EN_FT.
REQ-006 IDLE: -> FETCH when RUN=1 or STEP=1; otherwise remain.
REQ-007 FETCH: ROM_REQ=1 every cycle; on ROM_ACK=1, EN_FT=1 that same cycle and -> DECODE.
REQ-008 DECODE: EN_DC=1 one cycle; -> MEM if OP_CODE is LD (4'hd) or ST (4'he), else -> EXEC.
REQ-009 MEM: RAM_REQ=1 every cycle; on RAM_ACK=1 -> EXEC.
REQ-010 EXEC: EN_EX=1 one cycle; -> HALT if OP_CODE is HLT (4'hf), else -> WB.
REQ-011 WB: EN_WB=1 one cycle; INSN_CNT increments by 1, wrapping to 0 at all-ones; -> FETCH if RUN=1, else -> IDLE.
REQ-012 HALT and FAULT SHALL be absorbing; only RESET exits.
REQ-013 Latency: non-memory instruction with immediate ACK SHALL take exactly 4 cycles (FETCH, DECODE, EXEC, WB); LD/ST with immediate ACK exactly 5.
REQ-014 A wait counter SHALL clear on entry to FETCH/MEM and count cycles without ACK; on the cycle it reaches ACK_TO with ACK=0, -> FAULT.
REQ-015 ACK and timeout in the same cycle: ACK wins, normal transition.
REQ-016 ROM_ACK/RAM_ACK received while the matching REQ is low SHALL be ignored.
REQ-017 STEP outside IDLE SHALL be ignored; no queuing.
REQ-018 RUN deasserted mid-instruction: current instruction completes through WB, then -> IDLE.
REQ-019 At most one EN_* strobe SHALL be high in any cycle.

Reset
REQ-020 RESET=1 at a clock edge SHALL force IDLE, INSN_CNT=0, wait counter=0; all outputs 0 from that edge, including mid-fetch or mid-MEM (REQ drops).
REQ-021 RESET SHALL take priority over every transition, including HALT/FAULT exit.

Structure
REQ-022 Opcode constants (LD, ST, HLT) and state encodings SHALL live in shared package cpu15_pkg, used also by the exec and decode stages.
REQ-023 The wait/timeout counter SHALL be a sub-module wait_timer (inputs clear, count-enable; output expired).

Verification
REQ-024 RUN=1, ROM_ACK tied 1, OP_CODE=4'h1 -> strobe order EN_FT,EN_DC,EN_EX,EN_WB repeating every 4 cycles; INSN_CNT +1 per 4 cycles.
REQ-025 OP_CODE=4'hd, RAM_ACK delayed 3 cycles -> RAM_REQ high 4 cycles, EN_EX the cycle after RAM_ACK, instruction takes 8 cycles.
REQ-026 RUN=0, single STEP pulse, OP_CODE=4'h0 -> one instruction, INSN_CNT=1, back in IDLE; STEP pulsed during DECODE has no effect.
REQ-027 OP_CODE=4'hf -> EN_EX once, HALTED=1, no EN_WB, INSN_CNT unchanged; RUN/STEP ignored until RESET.
REQ-028 ROM_ACK held 0, ACK_TO=15 -> FAULT=1 after 15 FETCH cycles, ROM_REQ=0; ROM_ACK arriving on cycle 15 -> DECODE instead.
REQ-029 RESET asserted during MEM with RAM_REQ=1 -> next cycle all outputs 0, INSN_CNT=0; CNT_W=4, 16 instructions -> INSN_CNT wraps to 0.
